gold_code_correlator: RTL
=========================

Name: gold_code_correlator

Overview:
Receive-side counterpart of the Gold code generator. Contains a local Gold generator (two m-sequence LFSRs, outputs XORed) and correlates an incoming chip stream against it one period at a time. Slides the local phase until the correlation crosses a threshold, then tracks lock. Emits one despread data bit and one correlation count per code period.

Parameters:
POLY1, 6'b000011, feedback taps of LFSR 1
POLY2, 6'b100111, feedback taps of LFSR 2
SEED, 6'b101010, initial state of both LFSRs
LEN, 63, chips per code period
DEG, 6, LFSR length
THRESH, 56, minimum agreements (or minimum disagreements) counted as a match
MISS_MAX, 3, consecutive failed windows in LOCKED before lock is dropped

Ports:
clkin  in  1  clock
rst  in  1  synchronous reset, active-high
en  in  1  1 = run; 0 = return to IDLE
chip_in  in  1  received chip
chip_valid  in  1  chip_in is valid this cycle
corr_valid  out  1  one-cycle pulse at the end of each window
agree_cnt  out  6  agreements in the last window (0..LEN)
data_bit  out  1  despread bit: 0 if agree_cnt>=THRESH, 1 if agree_cnt<=LEN-THRESH
locked  out  1  in LOCKED state
phase_offset  out  6  local slips applied, mod LEN
lock_loss_cnt  out  8  debug counter (see Optional Feature)

Behaviour:
- Reset, or en=0: state IDLE; both LFSRs reload SEED; window and slip counters cleared. All outputs 0.
- IDLE -> SEARCH on the first cycle with en=1.
- Chips are consumed only when chip_valid=1. Gaps of any length are allowed and ignored.
- Per consumed chip: agree += (chip_in XNOR local_chip); both LFSRs step; chip counter increments.
- The window closes on the LEN-th consumed chip. In the following cycle:
  - corr_valid=1 for one cycle.
  - agree_cnt and data_bit are registered; they hold until the next window closes.
  - The accumulator and chip counter clear.
- match = (agree>=THRESH) or (agree<=LEN-THRESH).
- SEARCH, on match: go to LOCKED; locked=1 in the same cycle as corr_valid; miss counter cleared.
- SEARCH, no match: slip.
  - The next consumed chip is discarded: no accumulation, LFSRs hold.
  - phase_offset increments; LEN-1 wraps to 0.
  - The following chip starts a new window.
- LOCKED, match: miss counter cleared. No match: miss counter increments.
- LOCKED, miss counter reaches MISS_MAX: go to SEARCH; locked=0 with that corr_valid pulse; miss counter cleared; no slip on that window.
- data_bit is updated every window. It is meaningful only while locked=1 (or on the locking pulse).
- Precedence: rst > en=0 > window close > chip accumulate.
- chip_valid on the closing-pulse cycle is accepted normally as chip 1 of the next window, or as the slip chip.
- A window interrupted by en=0 or rst is discarded; no corr_valid is produced for it.

Optional Feature:
Macro GOLD_CORR_LOSS_CNT_EN.
- Defined: lock_loss_cnt increments on every LOCKED->SEARCH transition and saturates at 255. It clears only on rst.
- Not defined: lock_loss_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package gold_pkg holds:
  - default polynomials, SEED, LEN, DEG
  - state enum (IDLE, SEARCH, LOCKED)
  - width constant for agree_cnt and phase_offset, $clog2(LEN+1)
- Sub-module gold_lfsr, one per polynomial, parameters POLY, SEED and DEG:
  - inputs: load, step
  - output: current chip
- The top instantiates two gold_lfsr and XORs their outputs to form local_chip.

Test Plan:
- Aligned input (stream from a reference generator with the same params), 63 valid chips -> corr_valid on cycle 64; agree_cnt=63, data_bit=0, locked=1, phase_offset=0.
- Input delayed by 5 chips vs local -> five slipped windows, then lock; corr_valid with locked=1 after 5*64+63=383 consumed chips; phase_offset=5.
- Locked, next period inverted -> agree_cnt=0, data_bit=1, locked stays 1.
- Locked, 4 chip errors injected in one period -> agree_cnt=59, data_bit=0, locked stays 1; 8 errors -> agree_cnt=55, miss counter=1, locked stays 1.
- Locked, then 3 periods of all-zero-agreement-free noise (agree 20..40) -> locked drops on the 3rd corr_valid; lock_loss_cnt=1 with GOLD_CORR_LOSS_CNT_EN, 0 without.
- rst asserted after 30 chips of a window, and chip_valid toggled 1-in-3 -> outputs 0 during rst; the next window counts a full 63 consumed chips before corr_valid.

Source files
------------

// File: rtl/gold_pkg.sv
// Shared constants and types for the Gold code correlator: default code
// polynomials, seed, code length, match thresholds and the FSM state type.
package gold_pkg;

    localparam int DEG      = 6;
    localparam int LEN      = 63;
    localparam int THRESH   = 56;
    localparam int MISS_MAX = 3;

    localparam logic [DEG-1:0] POLY1 = 6'b000011;
    localparam logic [DEG-1:0] POLY2 = 6'b100111;
    localparam logic [DEG-1:0] SEED  = 6'b101010;

    // Width of agreement count and phase offset (holds 0..LEN).
    localparam int CW = $clog2(LEN + 1);

    localparam logic [CW-1:0] LEN_LAST  = CW'(LEN - 1);
    localparam logic [CW-1:0] THRESH_HI = CW'(THRESH);
    localparam logic [CW-1:0] THRESH_LO = CW'(LEN - THRESH);
    localparam logic [CW-1:0] HALF      = CW'(LEN / 2);
    localparam logic [1:0]    MISS_LAST = 2'(MISS_MAX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/gold_code_correlator_lfsr.sv
// One m-sequence generator of the Gold pair (module gold_lfsr).
// Fibonacci form: chip is state bit 0, the parity of the tapped bits
// enters at the top and the register shifts toward bit 0.
// load has priority over step; step advances by one chip.
module gold_lfsr #(
    parameter int           DEG  = 6,
    parameter logic [DEG-1:0] POLY = 6'b000011,
    parameter logic [DEG-1:0] SEED = 6'b101010
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic step_i,
    output logic chip_o
);

    logic [DEG-1:0] state_q;
    logic [DEG-1:0] state_d;

    // Next state: reload seed, advance one chip, or hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = {^(state_q & POLY), state_q[DEG-1:1]};
        end
    end

    // State register, seeded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign chip_o = state_q[0];

endmodule

// File: rtl/gold_code_correlator.sv
// Gold code correlator: compares each received chip with a locally generated
// Gold chip, totals agreements over one code period, slips the local phase by
// one chip after every failed search window, and tracks lock once found.
// Optional macro GOLD_CORR_LOSS_CNT_EN builds a saturating lock-loss counter.
module gold_code_correlator
    import gold_pkg::*;
(
    input  logic          clkin,
    input  logic          rst,
    input  logic          en,
    input  logic          chip_in,
    input  logic          chip_valid,
    output logic          corr_valid,
    output logic [CW-1:0] agree_cnt,
    output logic          data_bit,
    output logic          locked,
    output logic [CW-1:0] phase_offset,
    output logic [7:0]    lock_loss_cnt
);

    state_t        state_q, state_d;
    logic [CW-1:0] chip_cnt_q, chip_cnt_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [CW-1:0] agree_q, agree_d;
    logic [1:0]    miss_q, miss_d;
    logic          slip_q, slip_d;
    logic          corr_valid_q, corr_valid_d;
    logic          data_q, data_d;

    logic          chip1, chip2, local_chip;
    logic          active, consume, slip_take, close;
    logic          match;
    logic [CW-1:0] agree_now;

    // A chip is used for correlation unless it is the one discarded by a slip.
    assign active     = en && (state_q != IDLE);
    assign consume    = active && chip_valid && !slip_q;
    assign slip_take  = active && chip_valid && slip_q;
    assign close      = consume && (chip_cnt_q == LEN_LAST);
    assign local_chip = chip1 ^ chip2;
    assign agree_now  = acc_q + {{(CW-1){1'b0}}, chip_in ~^ local_chip};
    assign match      = (agree_now >= THRESH_HI) || (agree_now <= THRESH_LO);

    gold_lfsr #(.DEG(DEG), .POLY(POLY1), .SEED(SEED)) u_lfsr1 (
        .clk_i  (clkin),
        .rst_i  (rst),
        .load_i (!en),
        .step_i (consume),
        .chip_o (chip1)
    );

    gold_lfsr #(.DEG(DEG), .POLY(POLY2), .SEED(SEED)) u_lfsr2 (
        .clk_i  (clkin),
        .rst_i  (rst),
        .load_i (!en),
        .step_i (consume),
        .chip_o (chip2)
    );

    // Next-state: window accumulation, close-of-window decision, slip and lock tracking.
    always_comb begin
        state_d      = state_q;
        chip_cnt_d   = chip_cnt_q;
        acc_d        = acc_q;
        phase_d      = phase_q;
        agree_d      = agree_q;
        miss_d       = miss_q;
        slip_d       = slip_q;
        data_d       = data_q;
        corr_valid_d = 1'b0;
        if (!en) begin
            state_d    = IDLE;
            chip_cnt_d = '0;
            acc_d      = '0;
            phase_d    = '0;
            agree_d    = '0;
            miss_d     = '0;
            slip_d     = 1'b0;
            data_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                end
                SEARCH, LOCKED: begin
                    if (slip_take) begin
                        slip_d = 1'b0;
                    end else if (close) begin
                        corr_valid_d = 1'b1;
                        agree_d      = agree_now;
                        data_d       = (agree_now <= HALF);
                        acc_d        = '0;
                        chip_cnt_d   = '0;
                        if (state_q == SEARCH) begin
                            if (match) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end else begin
                                slip_d  = 1'b1;
                                phase_d = (phase_q == LEN_LAST) ? '0 : phase_q + CW'(1);
                            end
                        end else begin
                            if (match) begin
                                miss_d = '0;
                            end else if (miss_q == MISS_LAST) begin
                                state_d = SEARCH;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 2'd1;
                            end
                        end
                    end else if (consume) begin
                        acc_d      = agree_now;
                        chip_cnt_d = chip_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registers, cleared by synchronous reset.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q      <= IDLE;
            chip_cnt_q   <= '0;
            acc_q        <= '0;
            phase_q      <= '0;
            agree_q      <= '0;
            miss_q       <= '0;
            slip_q       <= 1'b0;
            data_q       <= 1'b0;
            corr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chip_cnt_q   <= chip_cnt_d;
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            agree_q      <= agree_d;
            miss_q       <= miss_d;
            slip_q       <= slip_d;
            data_q       <= data_d;
            corr_valid_q <= corr_valid_d;
        end
    end

`ifdef GOLD_CORR_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_ev;

    assign loss_ev = (state_q == LOCKED) && (state_d == SEARCH);

    // Lock-loss counter: survives en=0, saturates, cleared only by reset.
    always_ff @(posedge clkin) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_ev && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign corr_valid   = corr_valid_q;
    assign agree_cnt    = agree_q;
    assign data_bit     = data_q;
    assign locked       = (state_q == LOCKED);
    assign phase_offset = phase_q;

endmodule
